// File: rtl/fpga_cfg_pkg.sv
// Shared types and sizing helpers for the fabric bitstream loader.
// CFG_CHECKSUM_EN (optional) adds a trailer-word XOR check after the last column.
package fpga_cfg_pkg;

    localparam int unsigned DEFAULT_CFG_W     = 384;
    localparam int unsigned DEFAULT_NUM_COLS  = 267;
    localparam int unsigned DEFAULT_PRE_WAIT  = 10;
    localparam int unsigned DEFAULT_POST_WAIT = 10;
    localparam int unsigned DEFAULT_RDY_DELAY = 4;

    typedef enum logic [3:0] {
        StIdle,
        StPre,
        StAccept,
        StStrobe,
        StCheck,
        StPost,
        StFfen,
        StDone,
        StErr
    } cfg_state_e;

    // Bits needed to index n items (at least 1).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold values 0..max_val (at least 1).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cfg_checksum.sv
// XOR accumulator over accepted config words with a combinational compare port.
// Only instantiated when CFG_CHECKSUM_EN is defined.
module cfg_checksum
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned W = DEFAULT_CFG_W
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         clear,
    input  logic         accumulate,
    input  logic [W-1:0] data,
    input  logic [W-1:0] compare,
    output logic         match
);

    logic [W-1:0] acc;

    // Running XOR of every word accepted since the last clear.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (accumulate) begin
            acc <= acc ^ data;
        end
    end

    assign match = (acc == compare);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: takes one word per column over valid/ready, strobes it into the fabric,
// then raises ff_en and rdy after fixed delays.
// Optional feature macro: CFG_CHECKSUM_EN (trailer word checked against XOR of all words).
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CFG_W     = DEFAULT_CFG_W,
    parameter int unsigned NUM_COLS  = DEFAULT_NUM_COLS,
    parameter int unsigned PRE_WAIT  = DEFAULT_PRE_WAIT,
    parameter int unsigned POST_WAIT = DEFAULT_POST_WAIT,
    parameter int unsigned RDY_DELAY = DEFAULT_RDY_DELAY
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic [CFG_W-1:0]    configs_in,
    output logic [NUM_COLS-1:0] configs_en,
    output logic                ff_en,
    output logic                rdy,
    output logic                busy,
    output logic                err
);

    localparam int unsigned COL_W  = idx_w(NUM_COLS);
    localparam int unsigned WAIT_W = cnt_w(max3(PRE_WAIT, POST_WAIT, RDY_DELAY));

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [WAIT_W-1:0] PRE_LD   = WAIT_W'(PRE_WAIT);
    localparam logic [WAIT_W-1:0] POST_LD  = WAIT_W'(POST_WAIT);
    localparam logic [WAIT_W-1:0] RDY_LD   = WAIT_W'(RDY_DELAY);

    cfg_state_e        state;
    logic [COL_W-1:0]  col;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;

    // A wait of N occupies max(N,1) cycles in its state.
    assign wait_done = (wait_cnt <= WAIT_W'(1));
    assign busy      = !(state inside {StIdle, StDone, StErr});

`ifdef CFG_CHECKSUM_EN
    logic sum_clear;
    logic sum_accumulate;
    logic sum_match;

    assign cfg_ready      = (state == StAccept) || (state == StCheck);
    assign sum_clear      = start && (state inside {StIdle, StDone, StErr});
    assign sum_accumulate = (state == StAccept) && cfg_valid;

    cfg_checksum #(
        .W(CFG_W)
    ) u_checksum (
        .clock      (clock),
        .rst        (rst),
        .clear      (sum_clear),
        .accumulate (sum_accumulate),
        .data       (cfg_data),
        .compare    (cfg_data),
        .match      (sum_match)
    );
`else
    assign cfg_ready = (state == StAccept);
    assign err       = 1'b0;
`endif

    // Load sequencer; all fabric-facing outputs are registered here.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            col        <= '0;
            wait_cnt   <= '0;
            configs_in <= '0;
            configs_en <= '0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            err        <= 1'b0;
`endif
        end else begin
            // Column strobe is a single-cycle pulse.
            configs_en <= '0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StPre;
                        col      <= '0;
                        wait_cnt <= PRE_LD;
                    end
                end
                StPre: begin
                    if (wait_done) state <= StAccept;
                    else           wait_cnt <= wait_cnt - 1'b1;
                end
                StAccept: begin
                    // cfg_ready is high in this state, so valid alone completes the handshake.
                    if (cfg_valid) begin
                        configs_in <= cfg_data;
                        configs_en <= NUM_COLS'(1) << col;
                        state      <= StStrobe;
                    end
                end
                StStrobe: begin
                    if (col == LAST_COL) begin
                        wait_cnt <= POST_LD;
`ifdef CFG_CHECKSUM_EN
                        state    <= StCheck;
`else
                        state    <= StPost;
`endif
                    end else begin
                        col   <= col + 1'b1;
                        state <= StAccept;
                    end
                end
`ifdef CFG_CHECKSUM_EN
                StCheck: begin
                    if (cfg_valid) begin
                        if (sum_match) begin
                            state    <= StPost;
                            wait_cnt <= POST_LD;
                        end else begin
                            state <= StErr;
                            err   <= 1'b1;
                        end
                    end
                end
                StErr: begin
                    if (start) begin
                        err      <= 1'b0;
                        col      <= '0;
                        wait_cnt <= PRE_LD;
                        state    <= StPre;
                    end
                end
`endif
                StPost: begin
                    if (wait_done) begin
                        state    <= StFfen;
                        ff_en    <= 1'b1;
                        wait_cnt <= RDY_LD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StFfen: begin
                    if (wait_done) begin
                        state <= StDone;
                        rdy   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StDone: begin
                    // Reload: fabric drops out of run mode on the same edge.
                    if (start) begin
                        ff_en    <= 1'b0;
                        rdy      <= 1'b0;
                        col      <= '0;
                        wait_cnt <= PRE_LD;
                        state    <= StPre;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Randomized self-checking bench for fpga_cfg_loader (small geometry).
module tb_fpga_cfg_loader;

    localparam int unsigned CFG_W     = 8;
    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned PRE_WAIT  = 2;
    localparam int unsigned POST_WAIT = 2;
    localparam int unsigned RDY_DELAY = 3;
`ifdef CFG_CHECKSUM_EN
    localparam int HAS_SUM = 1;
`else
    localparam int HAS_SUM = 0;
`endif

    logic                clock = 1'b0;
    logic                rst;
    logic                start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic [CFG_W-1:0]    configs_in;
    logic [NUM_COLS-1:0] configs_en;
    logic                ff_en;
    logic                rdy;
    logic                busy;
    logic                err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fpga_cfg_loader #(
        .CFG_W     (CFG_W),
        .NUM_COLS  (NUM_COLS),
        .PRE_WAIT  (PRE_WAIT),
        .POST_WAIT (POST_WAIT),
        .RDY_DELAY (RDY_DELAY)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] w[NUM_COLS]);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < NUM_COLS; i++) s = s ^ w[i];
        return s;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(cfg_ready), 0);
        check({tag, "_cin"}, 32'(configs_in), 0);
        check({tag, "_cen"}, 32'(configs_en), 0);
        check({tag, "_ffen"}, 32'(ff_en), 0);
        check({tag, "_rdy"}, 32'(rdy), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // One full load as seen from outside: start pulse, stream words (+ trailer), watch strobes
    // and the ff_en/rdy timing. Cycle k counts negedges after the one that drove start.
    task automatic run_load(input logic [7:0] words[NUM_COLS], input logic [7:0] trailer,
                            input int max_gap, input bit poke_start, input int abort_after,
                            input bit expect_err);
        int   idx         = 0;
        int   gap         = 0;
        int   exp_col     = 0;
        int   last_strobe = -1;
        int   last_item   = -1;
        int   first_ready = -1;
        int   ff_cyc      = -1;
        int   rdy_cyc     = -1;
        int   err_cyc     = -1;
        int   n_items     = NUM_COLS + HAS_SUM;
        bit   finished    = 1'b0;
        logic prev_ff     = ff_en;
        logic prev_rdy    = rdy;
        start     = 1'b1;
        cfg_valid = 1'b0;
        for (int k = 1; k <= 400 && !finished; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 1) begin
                check("start_ffen_low", 32'(ff_en), 0);
                check("start_rdy_low", 32'(rdy), 0);
                check("start_err_low", 32'(err), 0);
                check("start_busy", 32'(busy), 1);
            end
            if (cfg_ready && first_ready < 0) first_ready = k;
            if (!busy && cfg_ready) check("ready_not_busy", 32'(cfg_ready), 0);
            if (configs_en != '0) begin
                check("ready_in_strobe", 32'(cfg_ready), 0);
                if (exp_col < NUM_COLS) begin
                    check("strobe_col", 32'(configs_en), 32'(1) << exp_col);
                    check("strobe_data", 32'(configs_in), 32'(words[exp_col]));
                end else begin
                    check("extra_strobe", 32'(configs_en), 0);
                end
                exp_col++;
                last_strobe = k;
                if (poke_start && exp_col == 2) start = 1'b1;
                if (abort_after > 0 && exp_col == abort_after) return;
            end else if (last_strobe > 0 && k == last_strobe + 1 && exp_col <= NUM_COLS) begin
                check("data_hold", 32'(configs_in), 32'(words[exp_col-1]));
            end
            if (ff_en && !prev_ff && ff_cyc < 0) ff_cyc = k;
            if (rdy && !prev_rdy && rdy_cyc < 0) rdy_cyc = k;
            prev_ff  = ff_en;
            prev_rdy = rdy;
            if (err && err_cyc < 0) err_cyc = k;
            if (rdy_cyc > 0 && k > rdy_cyc) check("run_hold", {30'd0, ff_en, rdy}, 3);
            if (err_cyc > 0) check("err_outputs", {29'd0, ff_en, rdy, |configs_en}, 0);
            if (rdy_cyc > 0 && k >= rdy_cyc + 2) finished = 1'b1;
            if (err_cyc > 0 && k >= err_cyc + 3) finished = 1'b1;
            // Drive the stream for the coming edge; consumed iff valid meets ready.
            if (idx < n_items) begin
                if (gap > 0) begin
                    cfg_valid = 1'b0;
                    cfg_data  = 8'($urandom);
                    gap--;
                end else begin
                    cfg_valid = 1'b1;
                    cfg_data  = (idx < NUM_COLS) ? words[idx] : trailer;
                    if (cfg_ready) begin
                        if (idx == NUM_COLS) last_item = k;
                        idx++;
                        gap = $urandom_range(max_gap, 0);
                    end
                end
            end else begin
                cfg_valid = 1'b0;
                cfg_data  = 8'($urandom);
            end
        end
        cfg_valid = 1'b0;
        check("strobe_count", 32'(exp_col), NUM_COLS);
        if (!expect_err) begin
            check("first_ready", 32'(first_ready), PRE_WAIT + 1);
            check("ffen_delay", 32'(ff_cyc - (HAS_SUM != 0 ? last_item : last_strobe)),
                  POST_WAIT + 1);
            check("rdy_delay", 32'(rdy_cyc - ff_cyc), RDY_DELAY);
            check("done_err", 32'(err), 0);
            check("done_busy", 32'(busy), 0);
        end else begin
            check("err_seen", 32'(err_cyc > 0), 1);
            check("err_delay", 32'(err_cyc - last_item), 1);
            check("err_no_ffen", 32'(ff_cyc), 32'hffff_ffff);
            check("err_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        logic [7:0] w[NUM_COLS];
        rst       = 1'b1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clock);

        // Basic load, valid held high.
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(w, 8'h44, 0, 1'b0, 0, 1'b0);

        // Back-pressure with random gaps, random words.
        for (int r = 0; r < 3; r++) begin
            foreach (w[i]) w[i] = 8'($urandom);
            run_load(w, xsum(w), 5, 1'b0, 0, 1'b0);
        end

        // Reset between word 2 and word 3, then a full reload from column 0.
        foreach (w[i]) w[i] = 8'($urandom);
        run_load(w, xsum(w), 1, 1'b0, 2, 1'b0);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        foreach (w[i]) w[i] = 8'($urandom);
        run_load(w, xsum(w), 2, 1'b0, 0, 1'b0);

        // Start pulsed during a strobe is ignored; run_load itself restarts from DONE.
        foreach (w[i]) w[i] = 8'($urandom);
        run_load(w, xsum(w), 3, 1'b1, 0, 1'b0);

`ifdef CFG_CHECKSUM_EN
        // Bad trailer -> error; a following start clears it and reloads.
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(w, 8'h45, 0, 1'b0, 0, 1'b1);
        run_load(w, 8'h44, 2, 1'b0, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
